dh_modexp_ctrl: RTL
===================

Name: dh_modexp_ctrl

Overview:
Sequencer for Diffie-Hellman modular exponentiation: computes result = base^e mod p by LSB-first square-and-multiply.
Owns one shared multiply-and-reduce datapath (multiplier plus quotient / multiply-back / subtract reduction pipeline) and schedules every multiply, square and base-reduction op through it.
Used for both key-exchange phases: R = g^x mod p, then K = R'^x mod p.
Start/done handshake toward the top-level key-exchange FSM.

Parameters:
WIDTH, 32, operand and modulus width; product is 2*WIDTH.
RED_LAT, 3, reduction pipeline registers, legal 1..3; each datapath op costs OPC = RED_LAT+1 cycles.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
base  in  WIDTH  base g (or peer public value), latched at start
e  in  WIDTH  private exponent, latched at start
p  in  WIDTH  modulus, latched at start
busy  out  1  high from cycle after start acceptance until done cycle inclusive
done  out  1  one-cycle pulse; result/err valid
result  out  WIDTH  base^e mod p; held until next accepted start
err  out  1  p==0 flagged; valid with done, held like result

Behaviour:
- Reset (async, rst=0): state IDLE, result=1, busy=0, done=0, err=0, pipeline cleared. Reset mid-operation aborts immediately; no done pulse.
- start while busy or done: ignored.
- Operands latched on the accepting edge.
- FSM states:
  - IDLE: start goes to LOAD.
  - LOAD: checks operands.
    - p==0: go to FIN with err=1, result=0.
    - e==0: go to FIN with result = (p==1 ? 0 : 1).
    - Otherwise: go to PREP.
  - PREP: issue b = base mod p (product forced to {0,base}).
  - WAIT: count OPC-1 cycles, then write back.
  - STEP: examine e[0].
    - If e[0]==1 and MUL not yet done for this bit: issue acc = acc*b mod p.
    - Else if e>>1 != 0: issue b = b*b mod p, then shift e right.
    - Else: go to FIN.
  - FIN: done=1, busy=1 this cycle, go to IDLE.
- Accumulator initialised to 1 in LOAD.
- Squaring is skipped after the top set bit.
- Exactly one op in flight; the datapath is never issued while WAIT counts.
- Latency, from the accepting edge to the done cycle:
  - N = 2 + OPC*(popcount(e)+bitlen(e)).
  - e==0 or p==0: N = 2.
- Arithmetic: product 2*WIDTH unsigned; reduction r = prod - (prod/p)*p; r < p guaranteed since p != 0.
- Boundaries:
  - p==1: result 0.
  - base >= p: handled by PREP.
  - e all ones: 2*WIDTH ops, no overflow of internal counters (bit counter width clog2(WIDTH)+1).
- busy=0 only in IDLE; done never coincides with IDLE.

Optional Feature:
Macro DH_MODEXP_CYCLE_CNT_EN.
- Defined: extra output cyc_cnt[15:0] counts cycles from acceptance through done (equals N).
  - Updated at done, reset to 0, saturates at 0xFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
1. base=5, e=3, p=23, RED_LAT=3 -> done at N=18 cycles after acceptance, result=10, err=0, busy high cycles 1..18.
2. base=5, e=6, p=23 -> result=8, N=2+4*(2+3)=22; then base=8, e=6, p=23 (second phase) -> result=8^6 mod 23=13, N=22.
3. e=0, p=23 -> result=1, N=2. e=0, p=1 -> result=0. base=7, e=5, p=0 -> err=1, result=0, N=2.
4. base=0xFFFFFFFF, e=0xFFFFFFFF, p=0xFFFFFFFB -> result=1024 (Fermat), N=258, no X on any output.
5. start re-pulsed every cycle during op of test 1 -> single done, result 10. Then rst=0 at cycle 9 of a new op -> result=1, busy=0, no done. Next start runs cleanly.
6. With DH_MODEXP_CYCLE_CNT_EN, rerun tests 1 and 4 -> cyc_cnt=18 and 258; without the macro, build has no cyc_cnt port.

Source files
------------

// File: rtl/dh_modexp_ctrl.sv
// Modular exponentiation sequencer (LSB-first square-and-multiply) around one shared multiply/reduce datapath.
// Optional DH_MODEXP_CYCLE_CNT_EN adds the cyc_cnt latency counter output.
module dh_modexp_ctrl #(
  parameter int WIDTH   = 32,
  parameter int RED_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
`ifdef DH_MODEXP_CYCLE_CNT_EN
  ,
  output logic [15:0]      cyc_cnt
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [1:0] WAIT_LAST = 2'(RED_LAT - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_PREP = 3'd2,
    S_WAIT = 3'd3, S_STEP = 3'd4, S_FIN  = 3'd5
  } state_t;

  typedef enum logic [1:0] {OP_RED = 2'd0, OP_MUL = 2'd1, OP_SQR = 2'd2} op_t;

  state_t           state_r, state_nx;
  op_t              op_r, op_s;
  logic             issue_s;
  logic [WIDTH-1:0] base_r, e_r, p_r, acc_r, b_r;
  logic             mul_done_r;
  logic [BW-1:0]    bits_r;
  logic [1:0]       wait_cnt_r;
  logic             wait_last_s, mul_need_s, sq_ok_s;
  logic             busy_r, done_r, err_r, err_nx;
  logic [WIDTH-1:0] result_r, res_nx;
  logic [PW-1:0]    prod_in_s, prod_a_r, prod_b_s;
  logic [WIDTH-1:0] quo_a_s, quo_b_s, rem_s, red_s;

  assign wait_last_s = (wait_cnt_r == WAIT_LAST);
  assign mul_need_s  = e_r[0] && !mul_done_r;
  assign sq_ok_s     = (e_r[WIDTH-1:1] != {(WIDTH-1){1'b0}}) && (bits_r < BW'(WIDTH - 1));

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= S_IDLE;
    else      state_r <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: if (start) state_nx = S_LOAD; else state_nx = S_IDLE;
      S_LOAD: begin
        if (p_r == {WIDTH{1'b0}} || e_r == {WIDTH{1'b0}}) state_nx = S_FIN;
        else                                             state_nx = S_PREP;
      end
      S_PREP: state_nx = S_WAIT;
      S_WAIT: begin
        // after the last multiply no square is needed, so skip straight to FIN
        if (!wait_last_s)                                                  state_nx = S_WAIT;
        else if (op_r == OP_MUL && e_r[WIDTH-1:1] == {(WIDTH-1){1'b0}})   state_nx = S_FIN;
        else                                                               state_nx = S_STEP;
      end
      S_STEP: begin
        if (mul_need_s || sq_ok_s) state_nx = S_WAIT;
        else                       state_nx = S_FIN;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // output / issue decode
  always_comb begin
    issue_s = 1'b0;
    op_s    = op_r;
    res_nx  = acc_r;
    err_nx  = 1'b0;
    case (state_r)
      S_LOAD: begin
        if (p_r == {WIDTH{1'b0}}) begin
          res_nx = {WIDTH{1'b0}};
          err_nx = 1'b1;
        end else if (p_r == ONE) begin
          res_nx = {WIDTH{1'b0}};
        end else begin
          res_nx = ONE;
        end
      end
      S_PREP: begin
        issue_s = 1'b1;
        op_s    = OP_RED;
      end
      S_WAIT: res_nx = red_s;
      S_STEP: begin
        if (mul_need_s) begin
          issue_s = 1'b1;
          op_s    = OP_MUL;
        end else if (sq_ok_s) begin
          issue_s = 1'b1;
          op_s    = OP_SQR;
        end else begin
          issue_s = 1'b0;
        end
      end
      default: issue_s = 1'b0;
    endcase
  end

  // operand select for the shared multiplier
  always_comb begin
    prod_in_s = {PW{1'b0}};
    case (op_s)
      OP_RED:  prod_in_s = {{WIDTH{1'b0}}, base_r};
      OP_MUL:  prod_in_s = {{WIDTH{1'b0}}, acc_r} * {{WIDTH{1'b0}}, b_r};
      OP_SQR:  prod_in_s = {{WIDTH{1'b0}}, b_r} * {{WIDTH{1'b0}}, b_r};
      default: prod_in_s = {PW{1'b0}};
    endcase
  end

  // product register, loaded only on issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         prod_a_r <= {PW{1'b0}};
    else if (issue_s) prod_a_r <= prod_in_s;
    else              prod_a_r <= prod_a_r;
  end

  // operands are always < p (or base for RED), so the quotient fits WIDTH bits
  assign quo_a_s = WIDTH'(prod_a_r / {{WIDTH{1'b0}}, p_r});

  generate
    if (RED_LAT >= 2) begin : g_quo_reg
      logic [PW-1:0]    prod_b_r;
      logic [WIDTH-1:0] quo_b_r;
      // quotient stage register
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          prod_b_r <= {PW{1'b0}};
          quo_b_r  <= {WIDTH{1'b0}};
        end else begin
          prod_b_r <= prod_a_r;
          quo_b_r  <= quo_a_s;
        end
      end
      assign prod_b_s = prod_b_r;
      assign quo_b_s  = quo_b_r;
    end else begin : g_quo_comb
      assign prod_b_s = prod_a_r;
      assign quo_b_s  = quo_a_s;
    end
  endgenerate

  assign rem_s = WIDTH'(prod_b_s - {{WIDTH{1'b0}}, quo_b_s} * {{WIDTH{1'b0}}, p_r});

  generate
    if (RED_LAT >= 3) begin : g_rem_reg
      logic [WIDTH-1:0] red_r;
      // multiply-back / subtract stage register
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) red_r <= {WIDTH{1'b0}};
        else      red_r <= rem_s;
      end
      assign red_s = red_r;
    end else begin : g_rem_comb
      assign red_s = rem_s;
    end
  endgenerate

  // operand latch, accumulator, exponent walk and op tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_r     <= {WIDTH{1'b0}};
      e_r        <= {WIDTH{1'b0}};
      p_r        <= {WIDTH{1'b0}};
      acc_r      <= ONE;
      b_r        <= {WIDTH{1'b0}};
      mul_done_r <= 1'b0;
      bits_r     <= {BW{1'b0}};
      wait_cnt_r <= 2'd0;
      op_r       <= OP_RED;
    end else begin
      if (state_r == S_IDLE && start) begin
        base_r <= base;
        e_r    <= e;
        p_r    <= p;
      end
      if (state_r == S_LOAD) begin
        acc_r      <= ONE;
        mul_done_r <= 1'b0;
        bits_r     <= {BW{1'b0}};
      end
      if (issue_s) begin
        op_r       <= op_s;
        wait_cnt_r <= 2'd0;
        if (op_s == OP_SQR) begin
          e_r        <= e_r >> 1;
          bits_r     <= bits_r + BW'(1);
          mul_done_r <= 1'b0;
        end
      end
      if (state_r == S_WAIT) begin
        if (wait_last_s) begin
          if (op_r == OP_MUL) begin
            acc_r      <= red_s;
            mul_done_r <= 1'b1;
          end else begin
            b_r <= red_s;
          end
        end else begin
          wait_cnt_r <= wait_cnt_r + 2'd1;
        end
      end
    end
  end

  // registered handshake and result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      result_r <= ONE;
    end else begin
      busy_r <= (state_nx != S_IDLE);
      done_r <= (state_nx == S_FIN);
      if (state_nx == S_FIN) begin
        result_r <= res_nx;
        err_r    <= err_nx;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign err    = err_r;

`ifdef DH_MODEXP_CYCLE_CNT_EN
  logic [15:0] run_r, cyc_r;
  // running latency counter, snapshotted as the done cycle is entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_r <= 16'd0;
      cyc_r <= 16'd0;
    end else begin
      if (state_r == S_IDLE && start)                 run_r <= 16'd1;
      else if (state_r != S_IDLE && run_r != 16'hFFFF) run_r <= run_r + 16'd1;
      else                                            run_r <= run_r;
      if (state_nx == S_FIN) cyc_r <= (run_r == 16'hFFFF) ? 16'hFFFF : run_r + 16'd1;
    end
  end
  assign cyc_cnt = cyc_r;
`endif

endmodule
